// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions for host transmitter and keyboard receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_INHIBIT,
      TX_RQST,
      TX_XFER,
      TX_ACK,
      TX_WAITREL
   } ps2_tx_state_e;

   localparam logic [7:0] PS2_CMD_LEDS  = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
   localparam logic [7:0] PS2_CMD_RATE  = 8'hF3;

   localparam int unsigned PS2_INHIBIT_CLKS  = 4950;
   localparam int unsigned PS2_INHIBIT_BITS  = 13;
   localparam int unsigned PS2_TIMEOUT_CLKS  = 750000;
   localparam int unsigned PS2_TIMEOUT_BITS  = 20;
   localparam int unsigned PS2_DEBOUNCE_CLKS = 63;
   localparam int unsigned PS2_DEBOUNCE_BITS = 6;

   function automatic logic ps2_odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: two-flop synchronizer, debounce and falling-edge strobe for a PS/2 line.
module ps2_clk_filter #(
   parameter int unsigned DEBOUNCE_CLKS = 63,
   parameter int unsigned DEBOUNCE_BITS = 6
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic line_i,
   output logic level_o,
   output logic fall_o
);

   localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = DEBOUNCE_BITS'(DEBOUNCE_CLKS - 1);

   logic [1:0]               sync_q;
   logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
   logic                     level_q, level_d, fall_q, fall_d, flip;

   // level flips on the DEBOUNCE_CLKS-th consecutive sample that differs from it
   always_comb begin
      flip    = (sync_q[1] != level_q) && (cnt_q == DB_MAX);
      cnt_d   = (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
      level_d = flip ? sync_q[1] : level_q;
      fall_d  = flip && level_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], line_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter on open-drain clock/data lines.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CLKS  = PS2_INHIBIT_CLKS,
   parameter int unsigned INHIBIT_BITS  = PS2_INHIBIT_BITS,
   parameter int unsigned TIMEOUT_CLKS  = PS2_TIMEOUT_CLKS,
   parameter int unsigned TIMEOUT_BITS  = PS2_TIMEOUT_BITS,
   parameter int unsigned DEBOUNCE_CLKS = PS2_DEBOUNCE_CLKS,
   parameter int unsigned DEBOUNCE_BITS = PS2_DEBOUNCE_BITS
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_n_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       tx_done_o,
   output logic       tx_err_o,
   output logic       rx_inhibit_o,
   inout  wire        ps2_clk_,
   inout  wire        ps2_data_
);

   localparam logic [INHIBIT_BITS-1:0] INH_MAX = INHIBIT_BITS'(INHIBIT_CLKS - 1);
   localparam logic [TIMEOUT_BITS-1:0] TO_MAX  = TIMEOUT_BITS'(TIMEOUT_CLKS);

   ps2_tx_state_e           state_q, state_d;
   logic [9:0]              sh_q, sh_d;
   logic [3:0]              bitcnt_q, bitcnt_d;
   logic [INHIBIT_BITS-1:0] inh_q, inh_d;
   logic [TIMEOUT_BITS-1:0] to_q, to_d;
   logic                    clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
   logic [1:0]              dsync_q;
   logic                    clk_lvl, fall, timed, done, err;

   ps2_clk_filter #(
      .DEBOUNCE_CLKS(DEBOUNCE_CLKS),
      .DEBOUNCE_BITS(DEBOUNCE_BITS)
   ) u_clk_filter (
      .clk_i  (wb_clk_i),
      .rst_n_i(wb_rst_n_i),
      .line_i (ps2_clk_),
      .level_o(clk_lvl),
      .fall_o (fall)
   );

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      bitcnt_d  = bitcnt_q;
      inh_d     = inh_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done      = 1'b0;
      err       = 1'b0;
      timed     = state_q inside {TX_RQST, TX_XFER, TX_ACK, TX_WAITREL};
      to_d      = timed ? to_q + 1'b1 : to_q;
      // the deadline takes priority over any fall seen in the same cycle
      if (timed && to_q == TO_MAX) begin
         err       = 1'b1;
         state_d   = TX_IDLE;
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
      end else begin
         case (state_q)
            TX_IDLE: if (tx_valid_i) begin
               sh_d     = {1'b1, ps2_odd_parity(tx_data_i), tx_data_i};
               clk_oe_d = 1'b1;
               inh_d    = '0;
               state_d  = TX_INHIBIT;
            end
            TX_INHIBIT: if (inh_q == INH_MAX) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               to_d      = '0;
               state_d   = TX_RQST;
            end else begin
               inh_d = inh_q + 1'b1;
            end
            TX_RQST: if (fall) begin
               data_oe_d = ~sh_q[0];
               sh_d      = {1'b1, sh_q[9:1]};
               bitcnt_d  = 4'd1;
               state_d   = TX_XFER;
            end
            // shift register holds data, parity and the stop bit (1 = release)
            TX_XFER: if (fall) begin
               data_oe_d = ~sh_q[0];
               sh_d      = {1'b1, sh_q[9:1]};
               bitcnt_d  = bitcnt_q + 4'd1;
               state_d   = (bitcnt_q == 4'd9) ? TX_ACK : TX_XFER;
            end
            TX_ACK: if (fall) begin
               err     = dsync_q[1];
               state_d = dsync_q[1] ? TX_IDLE : TX_WAITREL;
            end
            TX_WAITREL: if (clk_lvl && dsync_q[1]) begin
               done    = 1'b1;
               state_d = TX_IDLE;
            end
            default: begin
               state_d   = TX_IDLE;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q   <= TX_IDLE;
         sh_q      <= '0;
         bitcnt_q  <= '0;
         inh_q     <= '0;
         to_q      <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         dsync_q   <= 2'b11;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         bitcnt_q  <= bitcnt_d;
         inh_q     <= inh_d;
         to_q      <= to_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         dsync_q   <= {dsync_q[0], ps2_data_};
      end
   end

   assign ps2_clk_     = clk_oe_q  ? 1'b0 : 1'bz;
   assign ps2_data_    = data_oe_q ? 1'b0 : 1'bz;
   assign tx_ready_o   = (state_q == TX_IDLE);
   assign rx_inhibit_o = (state_q != TX_IDLE);
   assign tx_done_o    = done;
   assign tx_err_o     = err;

endmodule
